neuron_config_loader: RTL and testbench
=======================================

Name: neuron_config_loader

Overview:
- Writer side of the neuron weight/bias configuration interface.
- Fetches one layer's parameters from a synchronous parameter ROM.
- Streams them to neurons over weightValid/weightValue and biasValid/biasValue, tagged with config_layer_num/config_neuron_num.
- Sits between the parameter memory and the neuron array; one load per start pulse.

Parameters:
dataWidth, 16, width of weight/bias words and of layer/neuron number tags
numNeurons, 4, neurons in the layer being configured
numWeight, 5, weights per neuron (each neuron also gets exactly one bias)
layerNum, 0, constant value driven on config_layer_num
addrWidth, 8, ROM address width; must hold numNeurons*(numWeight+1)-1

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  begin a load; sampled only in IDLE
hold  input  1  suppress new ROM reads this cycle (back-pressure)
mem_rd_en  output  1  ROM read strobe
mem_addr  output  addrWidth  ROM read address
mem_data  input  dataWidth  ROM read data, valid the cycle after mem_rd_en
weightValid  output  1  weightValue carries a weight
weightValue  output  dataWidth  weight word
biasValid  output  1  biasValue carries a bias
biasValue  output  dataWidth  bias word
config_layer_num  output  dataWidth  layer tag, valid with weightValid/biasValid
config_neuron_num  output  dataWidth  target neuron index
busy  output  1  load in progress
done  output  1  one-cycle pulse at load completion

Behaviour:
- Reset (rst=0, asynchronous) clears all state and in-flight reads. All outputs are 0, except config_layer_num, which is layerNum. The FSM goes to IDLE.
- ROM layout: neuron n occupies addresses n*(numWeight+1) .. n*(numWeight+1)+numWeight. The first numWeight words are weights, in weight order. The last word is the bias.
- FSM states: IDLE, READ, DRAIN.
  - IDLE: on start=1 go to READ. Read counter and neuron counter clear to 0.
  - READ: each cycle with hold=0, assert mem_rd_en with mem_addr = read counter, then increment the counter. With hold=1, mem_rd_en=0 and the counter does not advance. After the read of the last address (numNeurons*(numWeight+1)-1), go to DRAIN.
  - DRAIN: wait until the last issued read has been output. Then pulse done for one cycle and return to IDLE.
- busy=1 in READ and DRAIN; busy=0 in the done cycle.
- Tag pipeline: each read carries a tag {neuron index, isBias} through a 1-deep register aligned with the ROM latency.
- Output timing: a read issued in cycle t returns mem_data in cycle t+1. That word is registered onto weightValue or biasValue, with the matching valid=1, in cycle t+2.
- Start-to-output latency: start sampled in cycle 0 → first read in cycle 1 → first weightValid in cycle 3.
- Throughput is one word per cycle with no bubbles while hold=0. Each hold cycle inserts exactly one bubble, two cycles later.
- weightValid and biasValid are never high in the same cycle.
- While valid is low, weightValue and biasValue hold their last values. config_neuron_num is updated with every valid word.
- start during READ/DRAIN is ignored. start held high across multiple cycles triggers exactly one load.
- hold has no effect in IDLE or DRAIN.
- Reset mid-load aborts the load, with no done pulse. A later start restarts from address 0.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- When defined: adds output port checksum [dataWidth-1:0].
  - Cleared to 0 on reset and in the cycle start is accepted.
  - Accumulates the modulo-2^dataWidth sum of every word output with weightValid or biasValid.
  - Holds its final value from the done cycle until the next start.
- When undefined: the port and the adder are absent. All other behaviour is identical.

Test Plan:
1. numNeurons=2, numWeight=5, ROM[i]=0x0100+i, start pulse at cycle 0, hold=0 → expected outputs:
   - weightValid cycles 3-7, values 0x0100-0x0104, neuron 0.
   - biasValid cycle 8, value 0x0105.
   - weightValid cycles 9-13, values 0x0106-0x010A, neuron 1.
   - biasValid cycle 14, value 0x010B.
   - done=1 in cycle 15 only; busy=1 in cycles 1-14.
2. Same setup, hold=1 in cycles 4-5 → expected outputs:
   - Words 0x0100-0x0102 in cycles 3-5; no valid in cycles 6-7; 0x0103 in cycle 8.
   - Remaining words contiguous; last bias in cycle 16; done in cycle 17.
3. start held high cycles 0-20 → exactly one load. A start pulse at cycle 10 (mid-load) changes nothing; a single done in cycle 15.
4. rst=0 asynchronously mid-cycle 6 for 2 cycles → all valids, busy and done go 0 immediately and no done follows. A new start streams again from 0x0100.
5. With LOADER_CHECKSUM_EN, scenario 1 → checksum=0x0C42 at done. With ROM filled with 0xFFFF (12 words) → checksum wraps to 0xFFF4.
6. numNeurons=1, numWeight=1, ROM={0x1234,0x5678} → weight 0x1234 in cycle 3, bias 0x5678 in cycle 4, done in cycle 5.

Source files
------------

// File: rtl/neuron_config_loader.sv
// Streams one layer's weights/biases from a synchronous parameter ROM to the neuron array.
// Optional LOADER_CHECKSUM_EN adds a running modulo-2^dataWidth checksum output.
module neuron_config_loader #(
  parameter int dataWidth  = 16,
  parameter int numNeurons = 4,
  parameter int numWeight  = 5,
  parameter int layerNum   = 0,
  parameter int addrWidth  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 hold,
  output logic                 mem_rd_en,
  output logic [addrWidth-1:0] mem_addr,
  input  logic [dataWidth-1:0] mem_data,
  output logic                 weightValid,
  output logic [dataWidth-1:0] weightValue,
  output logic                 biasValid,
  output logic [dataWidth-1:0] biasValue,
  output logic [dataWidth-1:0] config_layer_num,
  output logic [dataWidth-1:0] config_neuron_num,
  output logic                 busy,
  output logic                 done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [dataWidth-1:0] checksum
`endif
);

  localparam int WIDX_W = (numWeight < 1) ? 1 : $clog2(numWeight + 1);
  localparam logic [addrWidth-1:0] LAST_ADDR = addrWidth'(numNeurons * (numWeight + 1) - 1);
  localparam logic [WIDX_W-1:0]    BIAS_IDX  = WIDX_W'(numWeight);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  state_t                 state_q, state_d;
  logic                   start_q;
  logic [addrWidth-1:0]   rd_cnt_q, rd_cnt_d;
  logic [WIDX_W-1:0]      widx_q, widx_d;
  logic [dataWidth-1:0]   nrn_q, nrn_d;
  logic                   issue;
  logic                   accept;
  logic                   done_d;

  // Tag stage: aligned with the cycle the ROM presents mem_data
  logic                   pv_q;
  logic                   pb_q;
  logic [dataWidth-1:0]   pn_q;

  logic                   wv_q, bv_q, done_q;
  logic [dataWidth-1:0]   wval_q, bval_q, cnn_q;

  // Only a rising edge of start launches a load, so a held start loads once
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    widx_d   = widx_q;
    nrn_d    = nrn_q;
    issue    = 1'b0;
    accept   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        rd_cnt_d = '0;
        widx_d   = '0;
        nrn_d    = '0;
        if (start && !start_q) begin
          accept  = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        if (!hold) begin
          issue = 1'b1;
          if (rd_cnt_q == LAST_ADDR) begin
            state_d = DRAIN;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
          if (widx_q == BIAS_IDX) begin
            widx_d = '0;
            nrn_d  = nrn_q + 1'b1;
          end else begin
            widx_d = widx_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!pv_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      rd_cnt_q <= '0;
      widx_q   <= '0;
      nrn_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start;
      rd_cnt_q <= rd_cnt_d;
      widx_q   <= widx_d;
      nrn_q    <= nrn_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv_q <= 1'b0;
      pb_q <= 1'b0;
      pn_q <= '0;
    end else begin
      pv_q <= issue;
      pb_q <= (widx_q == BIAS_IDX);
      pn_q <= nrn_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wv_q   <= 1'b0;
      bv_q   <= 1'b0;
      wval_q <= '0;
      bval_q <= '0;
      cnn_q  <= '0;
    end else begin
      wv_q <= pv_q && !pb_q;
      bv_q <= pv_q && pb_q;
      if (pv_q && !pb_q) wval_q <= mem_data;
      if (pv_q && pb_q)  bval_q <= mem_data;
      if (pv_q)          cnn_q  <= pn_q;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [dataWidth-1:0] cks_q;

  // Summed at the tag stage so the total lands with the word's output cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cks_q <= '0;
    end else if (accept) begin
      cks_q <= '0;
    end else if (pv_q) begin
      cks_q <= cks_q + mem_data;
    end
  end

  assign checksum = cks_q;
`endif

  assign mem_rd_en         = issue;
  assign mem_addr          = rd_cnt_q;
  assign weightValid       = wv_q;
  assign weightValue       = wval_q;
  assign biasValid         = bv_q;
  assign biasValue         = bval_q;
  assign config_layer_num  = dataWidth'(layerNum);
  assign config_neuron_num = cnn_q;
  assign busy              = (state_q != IDLE);
  assign done              = done_q;

endmodule

// File: tb/tb_neuron_config_loader.sv
// Scoreboard bench: stimulus pushes expected words/done events, a negedge monitor pops and compares.
module tb_neuron_config_loader;

  localparam int DW = 16;
  localparam int AW = 8;

  typedef struct {
    int          cyc;
    int          kind;   // 0 weight, 1 bias, 2 done
    logic [15:0] val;    // word value, or checksum for done
    logic [15:0] nrn;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, hold, start_b, hold_b;

  logic          rd_a, wv_a, bv_a, busy_a, done_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] data_a, wval_a, bval_a, layer_a, cnn_a, cks_a;
  logic          rd_b, wv_b, bv_b, busy_b, done_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] data_b, wval_b, bval_b, layer_b, cnn_b, cks_b;

  logic [DW-1:0] rom_a [0:11];
  logic [DW-1:0] rom_b [0:1];

  ev_t sb_a[$];
  ev_t sb_b[$];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rd_a) data_a <= rom_a[addr_a];
  always @(posedge clk) if (rd_b) data_b <= rom_b[addr_b[0]];

  neuron_config_loader #(
    .dataWidth(DW), .numNeurons(2), .numWeight(5), .layerNum(0), .addrWidth(AW)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .mem_rd_en(rd_a), .mem_addr(addr_a), .mem_data(data_a),
    .weightValid(wv_a), .weightValue(wval_a), .biasValid(bv_a), .biasValue(bval_a),
    .config_layer_num(layer_a), .config_neuron_num(cnn_a), .busy(busy_a), .done(done_a)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(cks_a)
`endif
  );

  neuron_config_loader #(
    .dataWidth(DW), .numNeurons(1), .numWeight(1), .layerNum(3), .addrWidth(AW)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .hold(hold_b),
    .mem_rd_en(rd_b), .mem_addr(addr_b), .mem_data(data_b),
    .weightValid(wv_b), .weightValue(wval_b), .biasValid(bv_b), .biasValue(bval_b),
    .config_layer_num(layer_b), .config_neuron_num(cnn_b), .busy(busy_b), .done(done_b)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(cks_b)
`endif
  );

`ifndef LOADER_CHECKSUM_EN
  assign cks_a = '0;
  assign cks_b = '0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int which, input logic wv, input logic bv, input logic dn,
                     input logic bsy, input logic [15:0] wval, input logic [15:0] bval,
                     input logic [15:0] cnn, input logic [15:0] layer, input logic [15:0] cks,
                     input logic [15:0] exp_layer);
    ev_t e;
    int  k;
    if (wv && bv) chk("both_valid", 32'd1, 32'd0);
    if (wv || bv || dn) begin
      if ((which == 0 && sb_a.size() == 0) || (which == 1 && sb_b.size() == 0)) begin
        chk("unexpected_output", {29'd0, wv, bv, dn}, 32'd0);
      end else begin
        e = (which == 0) ? sb_a.pop_front() : sb_b.pop_front();
        k = dn ? 2 : (bv ? 1 : 0);
        chk("event_cycle", cyc, e.cyc);
        chk("event_kind", k, e.kind);
        if (e.kind == 0 && k == 0) chk("weight_value", wval, e.val);
        if (e.kind == 1 && k == 1) chk("bias_value", bval, e.val);
        if (e.kind != 2) begin
          chk("neuron_num", cnn, e.nrn);
          chk("layer_num", layer, exp_layer);
        end else begin
          chk("busy_at_done", bsy, 1'b0);
`ifdef LOADER_CHECKSUM_EN
          chk("checksum", cks, e.val);
`endif
        end
      end
    end
  endtask

  always @(negedge clk) mon(0, wv_a, bv_a, done_a, busy_a, wval_a, bval_a, cnn_a, layer_a, cks_a, 16'd0);
  always @(negedge clk) mon(1, wv_b, bv_b, done_b, busy_b, wval_b, bval_b, cnn_b, layer_b, cks_b, 16'd3);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected stream for dut_a: words at t0+3.., shifted by hl after a hold starting at t0+4
  task automatic push_a(input int t0, input int hl, input logic ones, input logic [15:0] cks);
    ev_t e;
    for (int i = 0; i < 12; i++) begin
      e.cyc  = t0 + 3 + i + ((i >= 3) ? hl : 0);
      e.kind = (i % 6 == 5) ? 1 : 0;
      e.val  = ones ? 16'hFFFF : 16'(16'h0100 + i);
      e.nrn  = 16'(i / 6);
      sb_a.push_back(e);
    end
    e.cyc  = t0 + 15 + hl;
    e.kind = 2;
    e.val  = cks;
    e.nrn  = '0;
    sb_a.push_back(e);
  endtask

  task automatic drain_a();
    int k = 0;
    while (sb_a.size() != 0 && k < 60) begin
      tick();
      k++;
    end
    repeat (4) tick();
    chk("sb_a_empty", sb_a.size(), 32'd0);
  endtask

  task automatic run_plain(input logic ones, input logic [15:0] cks);
    int t0;
    tick();
    t0 = cyc;
    start = 1'b1;
    push_a(t0, 0, ones, cks);
    for (int c = 1; c <= 16; c++) begin
      tick();
      start = 1'b0;
      chk("busy_window", busy_a, (c <= 14) ? 1'b1 : 1'b0);
      if (c == 1)  chk("first_read_addr", {rd_a, addr_a}, {1'b1, 8'd0});
      if (c == 12) chk("last_read_addr", {rd_a, addr_a}, {1'b1, 8'd11});
      if (c == 13) chk("no_read_in_drain", rd_a, 1'b0);
    end
    drain_a();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  t0;
    ev_t e;
    rst = 1'b0; start = 1'b0; hold = 1'b0; start_b = 1'b0; hold_b = 1'b0;
    for (int i = 0; i < 12; i++) rom_a[i] = 16'(16'h0100 + i);
    rom_b[0] = 16'h1234;
    rom_b[1] = 16'h5678;

    repeat (2) tick();
    chk("reset_busy", busy_a, 1'b0);
    chk("reset_done", done_a, 1'b0);
    chk("reset_valids", {wv_a, bv_a, rd_a}, 3'b000);
    chk("reset_values", {wval_a, bval_a, cnn_a}, 48'd0);
    chk("reset_addr", addr_a, 8'd0);
    chk("reset_layer_a", layer_a, 16'd0);
    chk("reset_layer_b", layer_b, 16'd3);
    rst = 1'b1;
    tick();

    // 1: plain load of 2 neurons x (5 weights + bias)
    run_plain(1'b0, 16'h0C42);

    // 2: hold in cycles 4-5 delays everything from word 3 on by two cycles
    tick();
    t0 = cyc;
    start = 1'b1;
    push_a(t0, 2, 1'b0, 16'h0C42);
    for (int c = 1; c <= 20; c++) begin
      tick();
      start = 1'b0;
      hold = (c == 4 || c == 5);
      #1;
      chk("hold_rd_en", rd_a, (c <= 14 && c != 4 && c != 5) ? 1'b1 : 1'b0);
    end
    hold = 1'b0;
    drain_a();

    // 3a: start held high for 21 cycles triggers one load
    tick();
    t0 = cyc;
    start = 1'b1;
    push_a(t0, 0, 1'b0, 16'h0C42);
    for (int c = 1; c <= 24; c++) begin
      tick();
      start = (c <= 20);
    end
    start = 1'b0;
    drain_a();

    // 3b: a second start pulse mid-load is ignored
    tick();
    t0 = cyc;
    start = 1'b1;
    push_a(t0, 0, 1'b0, 16'h0C42);
    for (int c = 1; c <= 20; c++) begin
      tick();
      start = (c == 10);
    end
    start = 1'b0;
    drain_a();

    // 4: asynchronous reset in cycle 6 aborts the load
    tick();
    t0 = cyc;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e.cyc = t0 + 3 + i; e.kind = 0; e.val = 16'(16'h0100 + i); e.nrn = '0;
      sb_a.push_back(e);
    end
    for (int c = 1; c <= 6; c++) begin
      tick();
      start = 1'b0;
    end
    #2;
    rst = 1'b0;
    #1;
    chk("abort_outputs", {wv_a, bv_a, busy_a, done_a, rd_a}, 5'b00000);
    tick();
    tick();
    #2;
    rst = 1'b1;
    repeat (20) tick();
    chk("abort_sb_empty", sb_a.size(), 32'd0);
    run_plain(1'b0, 16'h0C42);

`ifdef LOADER_CHECKSUM_EN
    // 5: checksum wraps with an all-ones ROM
    for (int i = 0; i < 12; i++) rom_a[i] = 16'hFFFF;
    run_plain(1'b1, 16'hFFF4);
`endif

    // 6: single neuron, single weight
    tick();
    t0 = cyc;
    start_b = 1'b1;
    e.cyc = t0 + 3; e.kind = 0; e.val = 16'h1234; e.nrn = '0; sb_b.push_back(e);
    e.cyc = t0 + 4; e.kind = 1; e.val = 16'h5678; e.nrn = '0; sb_b.push_back(e);
    e.cyc = t0 + 5; e.kind = 2; e.val = 16'h68AC; e.nrn = '0; sb_b.push_back(e);
    tick();
    start_b = 1'b0;
    chk("b_first_read", {rd_b, addr_b}, {1'b1, 8'd0});
    repeat (10) tick();
    chk("sb_b_empty", sb_b.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
